// File: rtl/rrf_pkg.sv
// Shared types for the retirement flag register write-side control.
package rrf_pkg;

  localparam int DATA_WIDTH = 6;

  typedef logic [DATA_WIDTH-1:0] flag_t;

  typedef struct packed {
    logic  thr;
    flag_t data;
  } flag_wr_t;

  typedef enum logic [1:0] {
    INIT0,
    INIT1,
    RUN
  } flag_ctrl_st_e;

endpackage

// File: rtl/rrf_flag_wr_ctrl_if.sv
// Retire, restore, flag write port and read forwarding signals of rrf_flag_wr_ctrl.
interface rrf_flag_wr_ctrl_if #(
  parameter int SLOTS = 4
);
  import rrf_pkg::*;

  logic                        ret_en;
  logic                        ret_thread;
  logic [SLOTS-1:0]            ret_wen;
  logic [SLOTS*DATA_WIDTH-1:0] ret_data;
  logic                        ret_stall;
  logic                        restore_en;
  logic                        restore_thread;
  flag_t                       restore_data;
  logic                        port_busy;
  flag_t                       wr_data;
  logic                        wr_wen;
  logic                        wr_thread;
  logic                        rd_thread;
  flag_t                       rrf_rd_data;
  flag_t                       rd_data;
  logic                        err_ovf;

  modport master (
    output ret_en, ret_thread, ret_wen, ret_data,
    output restore_en, restore_thread, restore_data,
    output port_busy, rd_thread, rrf_rd_data,
    input  ret_stall, wr_data, wr_wen, wr_thread, rd_data, err_ovf
  );

  modport slave (
    input  ret_en, ret_thread, ret_wen, ret_data,
    input  restore_en, restore_thread, restore_data,
    input  port_busy, rd_thread, rrf_rd_data,
    output ret_stall, wr_data, wr_wen, wr_thread, rd_data, err_ovf
  );

endinterface

// File: rtl/rrf_flag_wfifo.sv
// Pending flag-write FIFO kept compacted oldest-first, with thread purge and
// youngest-match search for read forwarding.
module rrf_flag_wfifo
  import rrf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  flag_wr_t      push_data,
  input  logic          pop,
  input  logic          purge,
  input  logic          purge_thr,
  input  logic          srch_thr,
  output logic          srch_hit,
  output flag_t         srch_data,
  output flag_wr_t      head,
  output logic [CW-1:0] count
);

  flag_wr_t      ent_q [DEPTH];
  flag_wr_t      ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  int            fill;

  // Survivors are repacked from slot 0 so the head is always ent_q[0];
  // a push lands behind the survivors, i.e. after any same-cycle purge.
  always_comb begin
    ent_d = ent_q;
    fill  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q) && !(pop && i == 0) &&
          !(purge && ent_q[i].thr == purge_thr)) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == fill) ent_d[j] = ent_q[i];
        end
        fill++;
      end
    end
    if (push) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == fill) ent_d[j] = push_data;
      end
      fill++;
    end
    count_d = CW'(fill);
  end

  always_comb begin
    srch_hit  = 1'b0;
    srch_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q) && ent_q[i].thr == srch_thr) begin
        srch_hit  = 1'b1;
        srch_data = ent_q[i].data;
      end
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: rtl/rrf_flag_wr_ctrl.sv
// Retirement flag write sequencer: youngest-slot select, pending-write FIFO,
// checkpoint restore priority and read forwarding of not-yet-written flags.
module rrf_flag_wr_ctrl
  import rrf_pkg::*;
#(
  parameter int    SLOTS      = 4,
  parameter int    DEPTH      = 4,
  parameter flag_t INIT_VALUE = '0
) (
  input logic              clk,
  input logic              rst,
  rrf_flag_wr_ctrl_if.slave bus
);

  // state | meaning
  // INIT0 | write INIT_VALUE to thread 0, hold while port busy
  // INIT1 | write INIT_VALUE to thread 1, hold while port busy
  // RUN   | restore > FIFO head > idle on the write port

  localparam int CW = $clog2(DEPTH) + 1;

  flag_ctrl_st_e state_q, state_d;
  logic          wr_wen_q, wr_wen_d;
  flag_t         wr_data_q, wr_data_d;
  logic          wr_thread_q, wr_thread_d;
  flag_t         rd_data_q, rd_data_d;
  logic          err_ovf_q, err_ovf_d;
  logic          pend_valid_q, pend_valid_d;
  flag_wr_t      pend_q, pend_d;

  logic          push_req, push, pop, full, in_init, ret_stall;
  flag_t         sel_data;
  flag_wr_t      head;
  logic [CW-1:0] count;
  logic          srch_hit;
  flag_t         srch_data;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (bus.ret_wen[i]) sel_data = bus.ret_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never makes room.
  assign in_init   = (state_q != RUN);
  assign full      = (count == CW'(DEPTH));
  assign ret_stall = in_init | full;
  assign push_req  = bus.ret_en & (|bus.ret_wen);
  assign push      = push_req & ~ret_stall;

  rrf_flag_wfifo #(.DEPTH(DEPTH)) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.ret_thread, sel_data}),
    .pop       (pop),
    .purge     (bus.restore_en),
    .purge_thr (bus.restore_thread),
    .srch_thr  (bus.rd_thread),
    .srch_hit  (srch_hit),
    .srch_data (srch_data),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d      = state_q;
    wr_wen_d     = 1'b0;
    wr_data_d    = wr_data_q;
    wr_thread_d  = wr_thread_q;
    pop          = 1'b0;
    err_ovf_d    = err_ovf_q | (push_req & ret_stall);
    pend_valid_d = pend_valid_q | bus.restore_en;
    pend_d       = bus.restore_en ? {bus.restore_thread, bus.restore_data} : pend_q;
    if (!bus.port_busy) begin
      case (state_q)
        INIT0: begin
          wr_wen_d    = 1'b1;
          wr_thread_d = 1'b0;
          wr_data_d   = INIT_VALUE;
          state_d     = INIT1;
        end
        INIT1: begin
          wr_wen_d    = 1'b1;
          wr_thread_d = 1'b1;
          wr_data_d   = INIT_VALUE;
          state_d     = RUN;
        end
        RUN: begin
          if (pend_valid_d) begin
            wr_wen_d     = 1'b1;
            wr_thread_d  = pend_d.thr;
            wr_data_d    = pend_d.data;
            pend_valid_d = 1'b0;
          end else if (count != '0) begin
            pop         = 1'b1;
            wr_wen_d    = 1'b1;
            wr_thread_d = head.thr;
            wr_data_d   = head.data;
          end
        end
        default: state_d = INIT0;
      endcase
    end
  end

  // Youngest first: same-cycle push, new restore (its thread's FIFO entries
  // are purged this cycle), FIFO, held restore, write in flight, array read.
  always_comb begin
    rd_data_d = bus.rrf_rd_data;
    if (push && bus.ret_thread == bus.rd_thread)
      rd_data_d = sel_data;
    else if (bus.restore_en && bus.restore_thread == bus.rd_thread)
      rd_data_d = bus.restore_data;
    else if (srch_hit)
      rd_data_d = srch_data;
    else if (pend_valid_q && pend_q.thr == bus.rd_thread)
      rd_data_d = pend_q.data;
    else if (wr_wen_q && wr_thread_q == bus.rd_thread)
      rd_data_d = wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT0;
      wr_wen_q     <= 1'b0;
      wr_data_q    <= '0;
      wr_thread_q  <= 1'b0;
      rd_data_q    <= '0;
      err_ovf_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_wen_q     <= wr_wen_d;
      wr_data_q    <= wr_data_d;
      wr_thread_q  <= wr_thread_d;
      rd_data_q    <= rd_data_d;
      err_ovf_q    <= err_ovf_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.ret_stall = ret_stall;
  assign bus.wr_wen    = wr_wen_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_thread = wr_thread_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_rrf_flag_wr_ctrl.sv
// Directed and random bench for rrf_flag_wr_ctrl against a queue-based reference model.
module tb_rrf_flag_wr_ctrl;

  localparam int SLOTS = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 6;
  localparam bit [DW-1:0] INIT_V = 6'h00;

  typedef struct packed {
    bit          thr;
    bit [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rrf_flag_wr_ctrl_if #(.SLOTS(SLOTS)) bus ();

  rrf_flag_wr_ctrl #(
    .SLOTS      (SLOTS),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t        mq[$];
  bit          m_pend_v;
  ent_t        m_pend;
  int          m_init_done;
  bit          e_wen, e_thr, e_err;
  bit [DW-1:0] e_wdata, e_rd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit          push_req, push_ok, wrote_restore;
    ent_t        sel, nq[$];
    bit [DW-1:0] fwd;
    if (rst) begin
      mq.delete();
      m_pend_v = 0; m_pend = '0; m_init_done = 0;
      e_wen = 0; e_thr = 0; e_wdata = '0; e_rd = '0; e_err = 0;
      return;
    end
    sel = '0;
    sel.thr = bus.ret_thread;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (bus.ret_wen[i]) begin
        sel.data = bus.ret_data[i*DW +: DW];
        break;
      end
    end
    push_req = bus.ret_en && (bus.ret_wen != '0);
    push_ok  = push_req && (m_init_done == 2) && (mq.size() < DEPTH);
    if (push_req && !push_ok) e_err = 1;

    // newest source with the read thread wins: layer from oldest to youngest
    fwd = bus.rrf_rd_data;
    if (e_wen && e_thr == bus.rd_thread) fwd = e_wdata;
    if (m_pend_v && m_pend.thr == bus.rd_thread) fwd = m_pend.data;
    foreach (mq[i])
      if (mq[i].thr == bus.rd_thread &&
          !(bus.restore_en && mq[i].thr == bus.restore_thread))
        fwd = mq[i].data;
    if (bus.restore_en && bus.restore_thread == bus.rd_thread) fwd = bus.restore_data;
    if (push_ok && sel.thr == bus.rd_thread) fwd = sel.data;
    e_rd = fwd;

    e_wen = 0;
    wrote_restore = 0;
    if (!bus.port_busy) begin
      if (m_init_done < 2) begin
        e_wen = 1; e_thr = (m_init_done == 1); e_wdata = INIT_V;
        m_init_done++;
      end else if (bus.restore_en) begin
        e_wen = 1; e_thr = bus.restore_thread; e_wdata = bus.restore_data;
        wrote_restore = 1;
      end else if (m_pend_v) begin
        e_wen = 1; e_thr = m_pend.thr; e_wdata = m_pend.data;
        m_pend_v = 0;
      end else if (mq.size() > 0) begin
        sel.thr = sel.thr; // keep sel intact; pop into a separate entry
        begin
          ent_t w;
          w = mq.pop_front();
          e_wen = 1; e_thr = w.thr; e_wdata = w.data;
        end
      end
    end
    if (bus.restore_en) begin
      foreach (mq[i]) if (mq[i].thr != bus.restore_thread) nq.push_back(mq[i]);
      mq = nq;
      m_pend_v = !wrote_restore;
      m_pend.thr = bus.restore_thread;
      m_pend.data = bus.restore_data;
    end
    if (push_ok) mq.push_back(sel);
  endtask

  task automatic tick();
    bit stall_exp;
    model_step();
    @(posedge clk);
    #1;
    stall_exp = (m_init_done < 2) || (mq.size() == DEPTH);
    chk("wr_wen", 8'(bus.wr_wen), 8'(e_wen));
    if (e_wen) begin
      chk("wr_data", 8'(bus.wr_data), 8'(e_wdata));
      chk("wr_thread", 8'(bus.wr_thread), 8'(e_thr));
    end
    chk("rd_data", 8'(bus.rd_data), 8'(e_rd));
    chk("err_ovf", 8'(bus.err_ovf), 8'(e_err));
    chk("ret_stall", 8'(bus.ret_stall), 8'(stall_exp));
  endtask

  task automatic bundle(input bit en, input bit thr, input bit [SLOTS-1:0] wen,
                        input int slot, input bit [DW-1:0] d);
    bus.ret_en     = en;
    bus.ret_thread = thr;
    bus.ret_wen    = wen;
    bus.ret_data   = 24'($urandom);
    bus.ret_data[slot*DW +: DW] = d;
  endtask

  task automatic rand_drive(input int busy_pct);
    bus.ret_en         = ($urandom_range(0, 2) != 0);
    bus.ret_thread     = 1'($urandom);
    bus.ret_wen        = 4'($urandom);
    bus.ret_data       = 24'($urandom);
    bus.restore_en     = ($urandom_range(0, 11) == 0);
    bus.restore_thread = 1'($urandom);
    bus.restore_data   = 6'($urandom);
    bus.port_busy      = ($urandom_range(0, 99) < busy_pct);
    bus.rd_thread      = 1'($urandom);
    bus.rrf_rd_data    = 6'($urandom);
  endtask

  initial begin
    bus.ret_en = 0; bus.ret_thread = 0; bus.ret_wen = '0; bus.ret_data = '0;
    bus.restore_en = 0; bus.restore_thread = 0; bus.restore_data = '0;
    bus.port_busy = 1; bus.rd_thread = 0; bus.rrf_rd_data = '0;

    // reset values
    rst = 1;
    tick(); tick();
    chk("rst_wr_data", 8'(bus.wr_data), 8'h00);
    chk("rst_wr_thread", 8'(bus.wr_thread), 8'h00);
    chk("rst_stall", 8'(bus.ret_stall), 8'h01);

    // INIT0 held by port_busy, then thread 0 and thread 1 init writes
    rst = 0;
    tick(); tick();
    chk("init_hold", 8'(bus.wr_wen), 8'h00);
    bus.port_busy = 0;
    tick();
    chk("init_t0", 8'({bus.wr_wen, bus.wr_thread}), 8'h02);
    tick();
    chk("init_t1", 8'({bus.wr_wen, bus.wr_thread}), 8'h03);
    chk("run_stall", 8'(bus.ret_stall), 8'h00);

    // youngest set slot (slot 2 of 4'b0101) is the one written
    bundle(1, 0, 4'b0101, 2, 6'h15);
    tick();
    bundle(0, 0, 4'b0000, 0, 6'h00);
    tick();
    chk("sel_slot2", 8'({bus.wr_wen, bus.wr_thread, bus.wr_data}), 8'h95);
    tick();

    // overflow: 4 queued, 5th rejected and flagged, then drained in order
    bus.port_busy = 1;
    for (int i = 0; i < 5; i++) begin
      bundle(1, 1, 4'b1000, 3, 6'(i + 1));
      tick();
    end
    bundle(0, 0, 4'b0000, 0, 6'h00);
    chk("ovf_err", 8'(bus.err_ovf), 8'h01);
    chk("ovf_stall", 8'(bus.ret_stall), 8'h01);
    bus.port_busy = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_last", 8'(bus.wr_data), 8'h04);
    tick();
    chk("ovf_empty", 8'(bus.wr_wen), 8'h00);

    // restore purges older thread-0 entries and goes first
    rst = 1; tick(); rst = 0; tick(); tick();
    bus.port_busy = 1;
    bundle(1, 0, 4'b0001, 0, 6'h01); tick();
    bundle(1, 0, 4'b0001, 0, 6'h02); tick();
    bundle(1, 1, 4'b0001, 0, 6'h03); tick();
    bundle(0, 0, 4'b0000, 0, 6'h00);
    bus.port_busy = 0;
    bus.restore_en = 1; bus.restore_thread = 0; bus.restore_data = 6'h3F;
    tick();
    chk("rst_first", 8'({bus.wr_thread, bus.wr_data}), 8'h3F);
    bus.restore_en = 0;
    tick();
    chk("rst_then_t1", 8'({bus.wr_thread, bus.wr_data}), 8'h43);
    tick();
    chk("rst_no_t0", 8'(bus.wr_wen), 8'h00);

    // forwarding of a pending entry vs array read
    bus.port_busy = 1;
    bus.rd_thread = 1; bus.rrf_rd_data = 6'h00;
    bundle(1, 1, 4'b0001, 0, 6'h2A);
    tick();
    chk("fwd_hit", 8'(bus.rd_data), 8'h2A);
    bundle(0, 0, 4'b0000, 0, 6'h00);
    bus.rd_thread = 0; bus.rrf_rd_data = 6'h11;
    tick();
    chk("fwd_miss", 8'(bus.rd_data), 8'h11);
    bus.port_busy = 0;
    tick(); tick();

    // random traffic, light then heavy port contention
    for (int i = 0; i < 300; i++) begin
      rand_drive(25);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      rand_drive(65);
      tick();
    end

    // reset with three entries queued: nothing queued may ever be written
    bus.restore_en = 0;
    bus.port_busy = 1;
    for (int i = 0; i < 3; i++) begin
      bundle(1, 0, 4'b0010, 1, 6'(i + 8));
      tick();
    end
    bundle(0, 0, 4'b0000, 0, 6'h00);
    rst = 1;
    tick();
    chk("mid_rst_err", 8'(bus.err_ovf), 8'h00);
    rst = 0;
    bus.port_busy = 0;
    tick(); tick();
    chk("mid_rst_init1", 8'({bus.wr_wen, bus.wr_thread, bus.wr_data}), 8'hC0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_idle", 8'(bus.wr_wen), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
